// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int MEM_SIZE   = 16;
    localparam int INDEX_BITS = 4;
    localparam int LINES      = 2 ** INDEX_BITS;
    localparam int TAG_BITS   = MEM_SIZE - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    // Word-aligned byte address: the index sits just above the two byte-offset bits.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int ib);
        return (pc >> 2) & ((32'd1 << ib) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int ib);
        return pc >> (ib + 2);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the cache: asynchronous read, one write port, bulk valid clear.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 10,
    parameter int DATA_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [DATA_BITS-1:0]  o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [DATA_BITS-1:0]  i_wr_data
);

    localparam int L_LINES = 2 ** INDEX_BITS;

    logic [L_LINES-1:0]   r_valid;
    logic [TAG_BITS-1:0]  r_tag  [L_LINES];
    logic [DATA_BITS-1:0] r_data [L_LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache between fetch stage and instruction memory.
module icache_dm
    import icache_pkg::*;
#(
    parameter int bit_size   = 32,
    parameter int mem_size   = 16,
    parameter int INDEX_BITS = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [mem_size-1:0] PC_in,
    input  logic                fetch_req,
    input  logic                ic_invalidate,
    output logic                IC_stall_out,
    output logic [bit_size-1:0] I_cache_instr_out,
    output logic [mem_size-1:0] IM_Address,
    output logic                IM_en_Read,
    input  logic [bit_size-1:0] Instruction,
    output logic [CNT_BITS-1:0] hit_cnt,
    output logic [CNT_BITS-1:0] miss_cnt
);

    localparam int L_TAG_BITS = mem_size - INDEX_BITS - 2;

    state_t                r_state, w_next;
    logic [mem_size-1:0]   r_miss_addr;
    logic [CNT_BITS-1:0]   r_hit_cnt, r_miss_cnt;
    logic [INDEX_BITS-1:0] w_rd_index, w_wr_index;
    logic [L_TAG_BITS-1:0] w_rd_tag, w_pc_tag, w_miss_tag;
    logic [bit_size-1:0]   w_rd_data;
    logic                  w_rd_valid, w_hit, w_miss, w_wr_en, w_clear;

    assign w_rd_index = INDEX_BITS'(pc_index(32'(PC_in), INDEX_BITS));
    assign w_pc_tag   = L_TAG_BITS'(pc_tag(32'(PC_in), INDEX_BITS));
    assign w_wr_index = INDEX_BITS'(pc_index(32'(r_miss_addr), INDEX_BITS));
    assign w_miss_tag = L_TAG_BITS'(pc_tag(32'(r_miss_addr), INDEX_BITS));

    assign w_hit   = (r_state == IDLE) && fetch_req && w_rd_valid && (w_rd_tag == w_pc_tag);
    assign w_miss  = (r_state == IDLE) && fetch_req && !w_hit;
    // An invalidate landing on the fill edge wins; the word is still bypassed to the CPU.
    assign w_wr_en = (r_state == FILL) && !ic_invalidate;
    assign w_clear = rst || ic_invalidate;

    icache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (L_TAG_BITS),
        .DATA_BITS  (bit_size)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_rd_index (w_rd_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_wr_index),
        .i_wr_tag   (w_miss_tag),
        .i_wr_data  (Instruction)
    );

    always_comb begin
        w_next            = r_state;
        IC_stall_out      = 1'b0;
        I_cache_instr_out = '0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    I_cache_instr_out = w_rd_data;
                end else if (w_miss) begin
                    IC_stall_out = 1'b1;
                    w_next       = REQ;
                end
            end
            REQ: begin
                IC_stall_out = 1'b1;
                w_next       = FILL;
            end
            FILL: begin
                I_cache_instr_out = Instruction;
                w_next            = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            IC_stall_out      = 1'b0;
            I_cache_instr_out = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss) begin
                r_miss_addr <= PC_in;
            end
            if (w_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + CNT_BITS'(1);
            end
            if (w_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + CNT_BITS'(1);
            end
        end
    end

    assign IM_en_Read = (r_state == REQ);
    assign IM_Address = r_miss_addr;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule
